// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bundle shared by the command-driven master and its register slave.
// The master modport drives requests; the slave modport returns readys and responses.
interface axi4_lite_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Command-driven AXI4-Lite master: one outstanding read or write, response returned on a
// valid/ready port, with an optional watchdog that aborts transactions to a hung slave.
module axi4_lite_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  axi4_lite_if.master       axi_if
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [3:0]        wstrb_q, wstrb_n;
  logic              awvalid_q, awvalid_n, wvalid_q, wvalid_n, bready_q, bready_n;
  logic              arvalid_q, arvalid_n, rready_q, rready_n;
  logic              rsp_valid_n, rsp_timeout_n;
  logic [31:0]       rsp_rdata_n;
  logic [1:0]        rsp_resp_n;
  logic              wd_fire, aw_ok, w_ok;

  // Gating with rst_n keeps cmd_ready low while reset is held even though the state is IDLE.
  assign cmd_ready = (state == IDLE) && rst_n;
  assign wd_fire   = (TIMEOUT_CYCLES > 0) && (cnt == CNT_LAST);
  assign aw_ok     = !awvalid_q || axi_if.awready;
  assign w_ok      = !wvalid_q  || axi_if.wready;

  assign axi_if.awaddr  = addr_q;
  assign axi_if.araddr  = addr_q;
  assign axi_if.wdata   = wdata_q;
  assign axi_if.wstrb   = wstrb_q;
  assign axi_if.awvalid = awvalid_q;
  assign axi_if.wvalid  = wvalid_q;
  assign axi_if.bready  = bready_q;
  assign axi_if.arvalid = arvalid_q;
  assign axi_if.rready  = rready_q;

  always_comb begin
    state_n       = state;
    addr_n        = addr_q;
    wdata_n       = wdata_q;
    wstrb_n       = wstrb_q;
    awvalid_n     = awvalid_q;
    wvalid_n      = wvalid_q;
    bready_n      = bready_q;
    arvalid_n     = arvalid_q;
    rready_n      = rready_q;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_resp_n    = rsp_resp;
    rsp_timeout_n = rsp_timeout;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_n  = cmd_addr;
          wdata_n = cmd_wdata;
          wstrb_n = cmd_wstrb;
          if (cmd_write) begin
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = WR_REQ;
          end else begin
            arvalid_n = 1'b1;
            state_n   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_q && axi_if.awready) awvalid_n = 1'b0;
        if (wvalid_q && axi_if.wready)   wvalid_n  = 1'b0;
        if (aw_ok && w_ok) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end else if (wd_fire) begin
          state_n = DONE;
        end
      end
      WR_RESP: begin
        if (axi_if.bvalid) begin
          bready_n      = 1'b0;
          rsp_resp_n    = axi_if.bresp;
          rsp_rdata_n   = '0;
          rsp_timeout_n = 1'b0;
          rsp_valid_n   = 1'b1;
          state_n       = DONE;
        end else if (wd_fire) begin
          state_n = DONE;
        end
      end
      RD_REQ: begin
        if (axi_if.arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_RESP;
        end else if (wd_fire) begin
          state_n = DONE;
        end
      end
      RD_RESP: begin
        if (axi_if.rvalid) begin
          rready_n      = 1'b0;
          rsp_resp_n    = axi_if.rresp;
          rsp_rdata_n   = axi_if.rdata;
          rsp_timeout_n = 1'b0;
          rsp_valid_n   = 1'b1;
          state_n       = DONE;
        end else if (wd_fire) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Watchdog abort: only reached when no completing handshake moved us elsewhere.
    if (state != DONE && state != IDLE && state_n == DONE && !rsp_valid_n) begin
      awvalid_n     = 1'b0;
      wvalid_n      = 1'b0;
      bready_n      = 1'b0;
      arvalid_n     = 1'b0;
      rready_n      = 1'b0;
      rsp_resp_n    = 2'b10;
      rsp_rdata_n   = '0;
      rsp_timeout_n = 1'b1;
      rsp_valid_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      wstrb_q     <= wstrb_n;
      awvalid_q   <= awvalid_n;
      wvalid_q    <= wvalid_n;
      bready_q    <= bready_n;
      arvalid_q   <= arvalid_n;
      rready_q    <= rready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_resp    <= rsp_resp_n;
      rsp_timeout <= rsp_timeout_n;
      if (state_n != state)
        cnt <= '0;
      else if (state != IDLE && state != DONE && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Randomized bench for axi4_lite_master: a 16-word register slave with tunable ready latencies
// sits on the AXI side, and a word-array model predicts every response the requester should see.
module tb_axi4_lite_master;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  axi4_lite_if #(.ADDR_W(32)) axi ();

  axi4_lite_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .axi_if(axi)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;

  int aw_lat = 0, w_lat = 0, ar_lat = 0;
  bit ar_never = 1'b0;
  int aw_hs = 0, w_hs = 0;
  int aw_wait, w_wait, ar_wait;
  logic aw_got, w_got;
  logic [31:0] aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;
  logic [31:0] slave_mem [16];
  logic [31:0] model_mem [16];

  // Register slave: ready raised a programmable number of cycles after its valid; unaligned -> SLVERR.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi.awready <= 1'b0; axi.wready <= 1'b0; axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0; w_wait <= 0;
      for (int i = 0; i < 16; i++) slave_mem[i] <= '0;
    end else begin
      if (axi.awvalid && axi.awready) begin
        axi.awready <= 1'b0; aw_got <= 1'b1; aw_addr_s <= axi.awaddr; aw_hs <= aw_hs + 1; aw_wait <= 0;
      end else if (axi.awvalid && !aw_got) begin
        if (aw_wait >= aw_lat) axi.awready <= 1'b1; else aw_wait <= aw_wait + 1;
      end
      if (axi.wvalid && axi.wready) begin
        axi.wready <= 1'b0; w_got <= 1'b1; w_data_s <= axi.wdata; w_strb_s <= axi.wstrb;
        w_hs <= w_hs + 1; w_wait <= 0;
      end else if (axi.wvalid && !w_got) begin
        if (w_wait >= w_lat) axi.wready <= 1'b1; else w_wait <= w_wait + 1;
      end
      if (aw_got && w_got && !axi.bvalid) begin
        aw_got <= 1'b0; w_got <= 1'b0; axi.bvalid <= 1'b1;
        if (aw_addr_s[1:0] != 2'b00) axi.bresp <= 2'b10;
        else begin
          axi.bresp <= 2'b00;
          for (int b = 0; b < 4; b++)
            if (w_strb_s[b]) slave_mem[aw_addr_s[5:2]][8*b +: 8] <= w_data_s[8*b +: 8];
        end
      end
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi.arready <= 1'b0; axi.rvalid <= 1'b0; axi.rdata <= '0; axi.rresp <= 2'b00; ar_wait <= 0;
    end else begin
      if (axi.arvalid && axi.arready) begin
        axi.arready <= 1'b0; axi.rvalid <= 1'b1; ar_wait <= 0;
        axi.rresp <= (axi.araddr[1:0] != 2'b00) ? 2'b10 : 2'b00;
        axi.rdata <= (axi.araddr[1:0] != 2'b00) ? 32'h0 : slave_mem[axi.araddr[5:2]];
      end else if (axi.arvalid && !ar_never && !axi.rvalid) begin
        if (ar_wait >= ar_lat) axi.arready <= 1'b1; else ar_wait <= ar_wait + 1;
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Issues one command, predicts its response from the model and checks the requester side.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int hold, input bit exp_to);
    logic [31:0] exp_rdata, mask;
    logic [1:0]  exp_resp;
    int n, aw0, w0, ar_cycles;
    bit aligned;
    aligned = (addr[1:0] == 2'b00);
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    if (exp_to) begin
      exp_resp = 2'b10; exp_rdata = 32'h0;
    end else if (wr) begin
      exp_resp = aligned ? 2'b00 : 2'b10; exp_rdata = 32'h0;
      if (aligned) model_mem[addr[5:2]] = (model_mem[addr[5:2]] & ~mask) | (data & mask);
    end else begin
      exp_resp = aligned ? 2'b00 : 2'b10;
      exp_rdata = aligned ? model_mem[addr[5:2]] : 32'h0;
    end
    aw0 = aw_hs; w0 = w_hs;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    checkOutput("cmd_accepted", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("req_valid_latency", 32'(wr ? (axi.awvalid & axi.wvalid) : axi.arvalid), 32'd1);
    ar_cycles = int'(axi.arvalid);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; ar_cycles += int'(axi.arvalid); end
    checkOutput("rsp_valid_arrived", 32'(rsp_valid), 32'd1);
    if (exp_to && !wr) checkOutput("arvalid_cycles", 32'(ar_cycles), 32'(TO));
    for (int i = 0; i < hold; i++) begin
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rsp_rdata", rsp_rdata, exp_rdata);
      checkOutput("hold_rsp_resp", 32'(rsp_resp), 32'(exp_resp));
      checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    checkOutput("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
    checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    if (wr && !exp_to) begin
      checkOutput("aw_handshakes", 32'(aw_hs - aw0), 32'd1);
      checkOutput("w_handshakes", 32'(w_hs - w0), 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
    checkOutput("cmd_ready_back", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] addr;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 32'd0);
    checkOutput("reset_awaddr", axi.awaddr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 0, 1'b0);
    applyStimulus(1'b1, 32'h0C, 32'h11223344, 4'hF, 0, 1'b0);
    applyStimulus(1'b1, 32'h0C, 32'hAABBCCDD, 4'b0101, 0, 1'b0);
    applyStimulus(1'b0, 32'h0C, 32'h0, 4'h0, 0, 1'b0);
    applyStimulus(1'b0, 32'h06, 32'h0, 4'h0, 0, 1'b0);

    aw_lat = 3; w_lat = 0;
    applyStimulus(1'b1, 32'h10, 32'h0BADF00D, 4'hF, 0, 1'b0);
    aw_lat = 0; w_lat = 3;
    applyStimulus(1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      aw_lat = $urandom_range(0, 4); w_lat = $urandom_range(0, 4); ar_lat = $urandom_range(0, 4);
      addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom), $urandom_range(0, 3), 1'b0);
    end

    applyStimulus(1'b1, 32'h20, 32'h5A5AA5A5, 4'hF, 10, 1'b0);

    ar_never = 1'b1;
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1);
    ar_never = 1'b0;

    aw_lat = 10; w_lat = 10;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h24; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("pre_reset_awvalid", 32'(axi.awvalid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_valids", 32'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 32'd0);
    checkOutput("midreset_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("midreset_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'd0);
    checkOutput("midreset_wdata", axi.wdata, 32'd0);
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    aw_lat = 1; w_lat = 2;
    @(negedge clk);
    applyStimulus(1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0);
    applyStimulus(1'b1, 32'h24, 32'h87654321, 4'b1100, 0, 1'b0);
    applyStimulus(1'b0, 32'h24, 32'h0, 4'h0, 2, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
